conv1d_stream_engine: RTL and testbench
=======================================

Name: conv1d_stream_engine

Overview:
Parametrised streaming 1-D convolution (FIR) engine, the next generation of our fixed convolution_engine. It generalises data width, coefficient width and tap count, and adds run-time coefficient loading, valid/ready back-pressure, frame boundaries, and a selectable rounding shift with saturate or wrap output. It sits between the pad/IO wrapper (sample source) and the output formatter (sample sink).

Parameters:
DATA_W, 8, signed input sample width
COEF_W, 8, signed coefficient width
TAPS, 4, number of taps, >=2
OUT_W, 8, signed output width
ACC_W, DATA_W+COEF_W+$clog2(TAPS), accumulator width (derived, not overridden)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
coef_wr_en  in  1  coefficient write strobe
coef_wr_addr  in  $clog2(TAPS)  tap index k
coef_wr_data  in  COEF_W  signed coefficient c[k]
cfg_shift  in  5  right-shift applied to the accumulator (0..ACC_W-1)
cfg_sat  in  1  1 = saturate to OUT_W, 0 = wrap (truncate)
in_valid  in  1  input sample valid
in_ready  out  1  engine can accept a sample
in_data  in  DATA_W  signed sample x[n]
in_last  in  1  marks the last sample of a frame
out_valid  out  1  output sample valid
out_ready  in  1  sink accepts the output
out_data  out  OUT_W  signed result y[n]
out_last  out  1  output belongs to the frame's last sample
short_frame  out  1  sticky: a frame ended before the window filled

Behaviour:
- Reset (async assert, sync-safe deassert): all coefficients 0, window 0, fill count 0, out_valid 0, out_data 0, out_last 0, short_frame 0, in_ready 1.
- Accept: a sample is taken on a rising edge where in_valid && in_ready. in_ready = !out_valid || out_ready (combinational). There is no other stall source.
- Window: on accept, shift x[n] into window slot 0 and move older samples up. Fill count saturates at TAPS.
- Compute: y[n] = sum over k=0..TAPS-1 of c[k]*x[n-k], evaluated in full-precision signed ACC_W arithmetic on the post-shift window.
- Output: produced only when the post-accept fill count == TAPS ("valid" convolution, no zero padding). out_valid rises on the edge after accept (latency 1). out_data, out_last and out_valid hold stable until out_valid && out_ready.
- Throughput: one sample per cycle when out_ready is held high. If the sink consumes and a new sample is accepted on the same edge, out_valid stays 1 with new data.
- Rounding: if cfg_shift > 0, r = (acc + 2^(cfg_shift-1)) >>> cfg_shift (arithmetic shift, round half up). If cfg_shift = 0, r = acc.
- Width: if cfg_sat = 1, clamp r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. If cfg_sat = 0, take r[OUT_W-1:0].
- in_last: the sample is accepted and computed normally, and its output (if any) carries out_last = 1. The fill count then clears to 0 and window contents clear to 0, so the next frame starts fresh.
- If in_last arrives with fill count < TAPS after accept, no output is produced and short_frame is set. short_frame clears only on reset.
- Coefficient write: allowed at any time, including mid-frame. The write lands at the edge. A sample accepted on the same edge uses the old c[k]; later samples use the new value.
- cfg_shift and cfg_sat are sampled on the accept edge of the sample they apply to.
- Reset mid-frame or with out_valid pending: the pending output is discarded, and the state returns to reset values, including coefficients.

Test Plan:
- TAPS=4, coefs c[0..3]=1,2,3,4, shift 0, sat 1, input 1,2,3,4,5 back-to-back, out_ready=1 -> no output for the first 3 samples; outputs 20 then 30, each 1 cycle after accept.
- Same coefs, shift 2, input 1..5 -> outputs 5 ((20+2)>>2) and 8 ((30+2)>>2).
- All coefs 127, all inputs 127, shift 0: sat=1 -> 127; sat=0 -> 4 (64516 mod 256). All coefs 127, all inputs -128, sat=1 -> -128.
- Back-pressure: hold out_ready=0 after the first output -> in_ready=0, out_data stays at 20 and remains stable. Release -> 30 follows, and no sample is lost or duplicated.
- Frames: 5-sample frame with in_last on the 5th, then 2-sample frame with in_last -> second output has out_last=1; the short frame gives no output and sets short_frame=1. The next 4-sample frame yields the first output on its 4th sample.
- Coef write on the same edge as the 4th sample accept (c[0]: 1->10) -> that output is 20; the next output is 5*10+8+9+8=75. Assert rst mid-frame -> all outputs 0 immediately and coefficients 0.

Source files
------------

// File: rtl/conv1d_stream_engine.sv
//==============================================================================
// Module      : conv1d_stream_engine
// Description : Streaming valid-mode 1-D FIR with run-time coefficients,
//               valid/ready flow control, frame boundaries and rounding shift.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module conv1d_stream_engine #(
    parameter int  DATA_W = 8,
    parameter int  COEF_W = 8,
    parameter int  TAPS   = 4,
    parameter int  OUT_W  = 8,
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS),
    localparam int ADDR_W = $clog2(TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              coef_wr_en_i,
    input  logic [ADDR_W-1:0] coef_wr_addr_i,
    input  logic [COEF_W-1:0] coef_wr_data_i,
    input  logic [4:0]        cfg_shift_i,
    input  logic              cfg_sat_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [OUT_W-1:0]  out_data_o,
    output logic              out_last_o,
    output logic              short_frame_o
);

    localparam int                    FILL_W    = $clog2(TAPS + 1);
    localparam logic [FILL_W-1:0]     FILL_FULL = FILL_W'(TAPS);
    localparam logic signed [ACC_W:0] OUT_MAX   = (ACC_W+1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] OUT_MIN   = ~OUT_MAX;

    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic signed [COEF_W-1:0] coef_d [TAPS];
    logic signed [DATA_W-1:0] win_q  [TAPS];
    logic signed [DATA_W-1:0] win_d  [TAPS];
    logic [FILL_W-1:0]        fill_q, fill_d;
    logic                     out_valid_q, out_valid_d;
    logic [OUT_W-1:0]         out_data_q, out_data_d;
    logic                     out_last_q, out_last_d;
    logic                     short_q, short_d;

    logic signed [DATA_W-1:0] w_win [TAPS];
    logic [FILL_W-1:0]        w_fill_inc;
    logic                     w_accept;
    logic                     w_produce;
    logic signed [ACC_W-1:0]  w_acc;
    logic signed [ACC_W:0]    w_round;
    logic signed [ACC_W:0]    w_sum;
    logic signed [ACC_W:0]    w_shifted;
    logic [OUT_W-1:0]         w_result;

    assign in_ready_o    = !out_valid_q || out_ready_i;
    assign w_accept      = in_valid_i && in_ready_o;
    assign out_valid_o   = out_valid_q;
    assign out_data_o    = out_data_q;
    assign out_last_o    = out_last_q;
    assign short_frame_o = short_q;

    // Window as it will look after the incoming sample is shifted in.
    generate
        for (genvar k = 0; k < TAPS; k++) begin : g_win
            if (k == 0) begin : g_head
                assign w_win[k] = in_data_i;
            end else begin : g_tail
                assign w_win[k] = win_q[k-1];
            end
        end
    endgenerate

    assign w_fill_inc = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
    assign w_produce  = (w_fill_inc == FILL_FULL);

    always_comb begin
        w_acc = '0;
        for (int k = 0; k < TAPS; k++) begin
            w_acc = w_acc + ACC_W'(coef_q[k]) * ACC_W'(w_win[k]);
        end
    end

    // One guard bit above the accumulator keeps the rounding add from overflowing.
    always_comb begin
        w_round = '0;
        if (cfg_shift_i != 5'd0) begin
            w_round = (ACC_W+1)'(1) <<< (cfg_shift_i - 5'd1);
        end
        w_sum     = $signed({w_acc[ACC_W-1], w_acc}) + w_round;
        w_shifted = w_sum >>> cfg_shift_i;
    end

    always_comb begin
        w_result = w_shifted[OUT_W-1:0];
        if (cfg_sat_i) begin
            if (w_shifted > OUT_MAX) begin
                w_result = OUT_MAX[OUT_W-1:0];
            end else if (w_shifted < OUT_MIN) begin
                w_result = OUT_MIN[OUT_W-1:0];
            end
        end
    end

    always_comb begin
        coef_d      = coef_q;
        win_d       = win_q;
        fill_d      = fill_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        short_d     = short_q;

        // The MAC above reads coef_q, so a same-edge write only affects later samples.
        if (coef_wr_en_i) begin
            coef_d[coef_wr_addr_i] = coef_wr_data_i;
        end

        if (w_accept) begin
            if (in_last_i) begin
                for (int k = 0; k < TAPS; k++) begin
                    win_d[k] = '0;
                end
                fill_d = '0;
                if (!w_produce) begin
                    short_d = 1'b1;
                end
            end else begin
                win_d  = w_win;
                fill_d = w_fill_inc;
            end

            if (w_produce) begin
                out_valid_d = 1'b1;
                out_data_d  = w_result;
                out_last_d  = in_last_i;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                coef_q[k] <= '0;
                win_q[k]  <= '0;
            end
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            short_q     <= 1'b0;
        end else begin
            coef_q      <= coef_d;
            win_q       <= win_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            short_q     <= short_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_conv1d_stream_engine.sv
//==============================================================================
// Module      : tb_conv1d_stream_engine
// Description : Self-checking bench for conv1d_stream_engine against a
//               frame-level arithmetic model, plus directed literal checks.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_conv1d_stream_engine;

    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int TAPS   = 4;
    localparam int OUT_W  = 8;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    coef_wr_en = 1'b0;
    logic [$clog2(TAPS)-1:0] coef_wr_addr = '0;
    logic [COEF_W-1:0]       coef_wr_data = '0;
    logic [4:0]              cfg_shift = '0;
    logic                    cfg_sat = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_data = '0;
    logic                    in_last = 1'b0;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic [OUT_W-1:0]        out_data;
    logic                    out_last;
    logic                    short_frame;

    int n_tests = 0;
    int n_fail  = 0;

    conv1d_stream_engine #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .coef_wr_en_i   (coef_wr_en),
        .coef_wr_addr_i (coef_wr_addr),
        .coef_wr_data_i (coef_wr_data),
        .cfg_shift_i    (cfg_shift),
        .cfg_sat_i      (cfg_sat),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_data_i      (in_data),
        .in_last_i      (in_last),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_data_o     (out_data),
        .out_last_o     (out_last),
        .short_frame_o  (short_frame)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int d;
        bit l;
    } exp_t;

    int   m_coef [TAPS];
    int   m_frame[$];
    exp_t m_q[$];
    bit   m_short;
    int   obs_d[$];
    bit   obs_l[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_out(input longint acc, input int sh, input bit sat);
        longint r;
        longint lo = -(longint'(1) <<< (OUT_W - 1));
        longint hi = (longint'(1) <<< (OUT_W - 1)) - 1;
        r = (sh > 0) ? ((acc + (longint'(1) <<< (sh - 1))) >>> sh) : acc;
        if (sat) begin
            if (r > hi) r = hi;
            if (r < lo) r = lo;
        end else begin
            r = r & ((longint'(1) <<< OUT_W) - 1);
            if (r > hi) r = r - (longint'(1) <<< OUT_W);
        end
        return int'(r);
    endfunction

    task automatic model_accept();
        longint acc;
        exp_t   e;
        int     n;
        m_frame.push_back(int'($signed(in_data)));
        n = m_frame.size();
        if (n >= TAPS) begin
            acc = 0;
            for (int k = 0; k < TAPS; k++) acc += longint'(m_coef[k]) * m_frame[n-1-k];
            e.d = model_out(acc, int'(cfg_shift), cfg_sat);
            e.l = in_last;
            m_q.push_back(e);
        end
        if (in_last) begin
            if (n < TAPS) m_short = 1'b1;
            m_frame.delete();
        end else if (n > TAPS) begin
            void'(m_frame.pop_front());
        end
    endtask

    // Compare process: the handshakes happen on the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) m_coef[k] = 0;
            m_frame.delete();
            m_q.delete();
            m_short = 1'b0;
        end else begin
            chk("in_ready_rule", in_ready, !out_valid || out_ready);
            chk("out_valid", out_valid, m_q.size() != 0);
            chk("short_frame", short_frame, m_short);
            if (out_valid && m_q.size() != 0) begin
                chk("out_data", int'($signed(out_data)), m_q[0].d);
                chk("out_last", out_last, m_q[0].l);
                if (out_ready) begin
                    obs_d.push_back(int'($signed(out_data)));
                    obs_l.push_back(out_last);
                    void'(m_q.pop_front());
                end
            end
            if (in_valid && in_ready) model_accept();
            if (coef_wr_en) m_coef[coef_wr_addr] = int'($signed(coef_wr_data));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input bit last);
        bit acc_seen = 1'b0;
        int tries    = 0;
        in_valid = 1'b1;
        in_data  = d[DATA_W-1:0];
        in_last  = last;
        while (!acc_seen && tries < 200) begin
            @(negedge clk);
            acc_seen = in_ready;
            @(posedge clk);
            #1;
            coef_wr_en = 1'b0;
            tries++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!acc_seen) chk("send_timeout", 0, 1);
    endtask

    task automatic set_coefs(input int c0, input int c1, input int c2, input int c3);
        int c[4];
        c = '{c0, c1, c2, c3};
        for (int k = 0; k < TAPS; k++) begin
            coef_wr_en   = 1'b1;
            coef_wr_addr = k[$clog2(TAPS)-1:0];
            coef_wr_data = c[k][COEF_W-1:0];
            idle(1);
        end
        coef_wr_en = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        out_ready = 1'b1;
        while (out_valid && t < 100) begin
            idle(1);
            t++;
        end
        chk("drain_done", out_valid, 0);
        idle(1);
    endtask

    task automatic chk_obs(input string name, input int idx, input int exp);
        if (idx < obs_d.size()) begin
            chk(name, obs_d[idx], exp);
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no output at index %0d, expected %0d", name, idx, exp);
        end
    endtask

    task automatic frame_1to5();
        for (int i = 1; i <= 5; i++) send(i, i == 5);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        rst = 1'b0;
        idle(1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_short", short_frame, 0);
        chk("rst_in_ready", in_ready, 1);

        // Basic: 20 then 30, second carries out_last
        set_coefs(1, 2, 3, 4);
        cfg_shift = 5'd0; cfg_sat = 1'b1;
        obs_d.delete(); obs_l.delete();
        frame_1to5();
        drain();
        chk("basic_count", obs_d.size(), 2);
        chk_obs("basic_y0", 0, 20);
        chk_obs("basic_y1", 1, 30);
        if (obs_l.size() >= 2) chk("basic_last", obs_l[1], 1);

        // Rounding shift of 2
        cfg_shift = 5'd2;
        obs_d.delete(); obs_l.delete();
        frame_1to5();
        drain();
        chk_obs("shift2_y0", 0, 5);
        chk_obs("shift2_y1", 1, 8);

        // Saturation and wrap
        cfg_shift = 5'd0;
        set_coefs(127, 127, 127, 127);
        obs_d.delete(); obs_l.delete();
        cfg_sat = 1'b1;
        for (int i = 0; i < 4; i++) send(127, i == 3);
        cfg_sat = 1'b0;
        for (int i = 0; i < 4; i++) send(127, i == 3);
        cfg_sat = 1'b1;
        for (int i = 0; i < 4; i++) send(-128, i == 3);
        drain();
        chk_obs("sat_pos", 0, 127);
        chk_obs("wrap", 1, 4);
        chk_obs("sat_neg", 2, -128);

        // Back-pressure
        set_coefs(1, 2, 3, 4);
        obs_d.delete(); obs_l.delete();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(i, 1'b0);
        fork
            send(5, 1'b1);
            begin
                repeat (4) begin
                    @(negedge clk);
                    chk("bp_in_ready", in_ready, 0);
                    chk("bp_hold", int'($signed(out_data)), 20);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", obs_d.size(), 2);
        chk_obs("bp_y0", 0, 20);
        chk_obs("bp_y1", 1, 30);

        // Short frame, then a fresh 4-sample frame
        obs_d.delete(); obs_l.delete();
        send(9, 1'b0);
        send(9, 1'b1);
        idle(1);
        chk("short_set", short_frame, 1);
        for (int i = 1; i <= 4; i++) send(i, i == 4);
        drain();
        chk("short_count", obs_d.size(), 1);
        chk_obs("short_next_y0", 0, 20);

        // Coefficient write on the same edge as the 4th sample
        obs_d.delete(); obs_l.delete();
        for (int i = 1; i <= 3; i++) send(i, 1'b0);
        coef_wr_en = 1'b1; coef_wr_addr = '0; coef_wr_data = 8'd10;
        send(4, 1'b0);
        send(5, 1'b1);
        drain();
        chk_obs("cw_old", 0, 20);
        chk_obs("cw_new", 1, 75);

        // Asynchronous reset with an output pending
        obs_d.delete(); obs_l.delete();
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(i, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_short", short_frame, 0);
        chk("arst_in_ready", in_ready, 1);
        idle(2);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(7, i == 3);
        drain();
        chk_obs("arst_coef_zero", 0, 0);

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            in_data      = DATA_W'($urandom);
            in_last      = ($urandom_range(0, 9) == 0);
            coef_wr_en   = ($urandom_range(0, 7) == 0);
            coef_wr_addr = $urandom_range(0, TAPS - 1);
            coef_wr_data = COEF_W'($urandom);
            out_ready    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 31) == 0) begin
                cfg_shift = 5'($urandom_range(0, 17));
                cfg_sat   = 1'($urandom_range(0, 1));
            end
            idle(1);
        end
        in_valid = 1'b0; in_last = 1'b0; coef_wr_en = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
